// File: rtl/fb_axi_pkg.sv
// Shared definitions for the framebuffer AXI write responder:
// AXI burst/response codes, the only legal beat size, default geometry
// and the responder FSM state type.
package fb_axi_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned LEN_W  = 8;

    localparam logic [31:0]  FB_BASE_DEF  = 32'h0000_0000;
    localparam int unsigned  FB_WORDS_DEF = 76800;
    localparam int unsigned  MEM_AW_DEF   = 17;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_WORD   = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/fb_wr_addr_gen.sv
// Per-beat address generator for one write burst.
// Holds the current byte address, advances it on each accepted beat
// (INCR: +4 modulo 2^32, FIXED/other: hold) and derives the SRAM word
// index plus an in-window flag.
// Optional: FB_WR_RANGE_CHECK_EN enables the framebuffer window check.
// Ports:
//   clk, rst        clock, async active-high reset
//   load            latch load_addr/load_burst (AW handshake)
//   load_addr       burst start byte address
//   load_burst      AXI burst type
//   advance         step to the next beat address (W handshake)
//   word_idx_c      SRAM word index of the current beat
//   in_range_c      current beat lies inside the framebuffer window
module fb_wr_addr_gen
    import fb_axi_pkg::*;
#(
    parameter logic [31:0] FB_BASE  = FB_BASE_DEF,
    parameter int unsigned FB_WORDS = FB_WORDS_DEF,
    parameter int unsigned MEM_AW   = MEM_AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [1:0]          load_burst,
    input  logic                advance,
    output logic [MEM_AW-1:0]   word_idx_c,
    output logic                in_range_c
);

    logic [ADDR_W-1:0] addr;
    logic [1:0]        burst;

    // Current beat address; only INCR bursts move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr  <= '0;
            burst <= BURST_FIXED;
        end else if (load) begin
            addr  <= load_addr;
            burst <= load_burst;
        end else if (advance && (burst == BURST_INCR)) begin
            addr  <= addr + ADDR_W'(4);
        end
    end

`ifdef FB_WR_RANGE_CHECK_EN
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] idx;

    // Unsigned offset: addresses below the base wrap to huge indices and fail the check.
    assign offset     = addr - FB_BASE;
    assign idx        = offset >> 2;
    assign in_range_c = (idx < ADDR_W'(FB_WORDS));
    assign word_idx_c = idx[MEM_AW-1:0];
`else
    logic unused_bits;

    assign word_idx_c  = addr[MEM_AW+1:2];
    assign in_range_c  = 1'b1;
    assign unused_bits = ^{addr[ADDR_W-1:MEM_AW+2], addr[1:0], FB_BASE, ADDR_W'(FB_WORDS)};
`endif

endmodule

// File: rtl/fb_axi_wr_slave.sv
// AXI4 write-channel responder terminating the framebuffer write path.
// Accepts one burst at a time, writes each legal beat to the SRAM write
// port one cycle after its W handshake and returns one B per burst.
// Optional: FB_WR_RANGE_CHECK_EN (see fb_wr_addr_gen) suppresses beats
// outside the framebuffer window and flags SLVERR.
// Ports:
//   clk, rst                       clock, async active-high reset
//   fb_aw_*                        write address channel (slave side)
//   fb_w_*                         write data channel (slave side)
//   fb_b_*                         write response channel (slave side)
//   mem_we/addr/wdata/wstrb        SRAM write port (registered)
//   busy                           a burst is in flight
module fb_axi_wr_slave
    import fb_axi_pkg::*;
#(
    parameter logic [31:0] FB_BASE  = FB_BASE_DEF,
    parameter int unsigned FB_WORDS = FB_WORDS_DEF,
    parameter int unsigned MEM_AW   = MEM_AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fb_aw_valid,
    input  logic [ADDR_W-1:0]   fb_aw_addr,
    input  logic [LEN_W-1:0]    fb_aw_len,
    input  logic [2:0]          fb_aw_size,
    input  logic [1:0]          fb_aw_burst,
    output logic                fb_aw_ready,
    input  logic [DATA_W-1:0]   fb_w_data,
    input  logic [STRB_W-1:0]   fb_w_strb,
    input  logic                fb_w_last,
    input  logic                fb_w_valid,
    output logic                fb_w_ready,
    output logic                fb_b_valid,
    output logic [1:0]          fb_b_resp,
    input  logic                fb_b_ready,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [STRB_W-1:0]   mem_wstrb,
    output logic                busy
);

    wr_state_e          state, state_nxt;
    logic [LEN_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic               err, err_nxt;
    logic               bad_burst, bad_burst_nxt;

    logic               aw_ready_nxt, w_ready_nxt, b_valid_nxt, busy_nxt;
    logic [1:0]         b_resp_nxt;
    logic               mem_we_nxt;
    logic [MEM_AW-1:0]  mem_addr_nxt;
    logic [DATA_W-1:0]  mem_wdata_nxt;
    logic [STRB_W-1:0]  mem_wstrb_nxt;

    logic               ag_load, ag_advance;
    logic [MEM_AW-1:0]  word_idx_c;
    logic               in_range_c;
    logic               last_beat_c;

    fb_wr_addr_gen #(
        .FB_BASE  (FB_BASE),
        .FB_WORDS (FB_WORDS),
        .MEM_AW   (MEM_AW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (ag_load),
        .load_addr  (fb_aw_addr),
        .load_burst (fb_aw_burst),
        .advance    (ag_advance),
        .word_idx_c (word_idx_c),
        .in_range_c (in_range_c)
    );

    // State, bookkeeping and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            beat_cnt    <= '0;
            err         <= 1'b0;
            bad_burst   <= 1'b0;
            fb_aw_ready <= 1'b1;
            fb_w_ready  <= 1'b0;
            fb_b_valid  <= 1'b0;
            fb_b_resp   <= RESP_OKAY;
            busy        <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
        end else begin
            state       <= state_nxt;
            beat_cnt    <= beat_cnt_nxt;
            err         <= err_nxt;
            bad_burst   <= bad_burst_nxt;
            fb_aw_ready <= aw_ready_nxt;
            fb_w_ready  <= w_ready_nxt;
            fb_b_valid  <= b_valid_nxt;
            fb_b_resp   <= b_resp_nxt;
            busy        <= busy_nxt;
            mem_we      <= mem_we_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_wdata   <= mem_wdata_nxt;
            mem_wstrb   <= mem_wstrb_nxt;
        end
    end

    assign last_beat_c = (beat_cnt == '0);

    // Next state, beat accounting and SRAM write decision.
    always_comb begin
        state_nxt     = state;
        beat_cnt_nxt  = beat_cnt;
        err_nxt       = err;
        bad_burst_nxt = bad_burst;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_wstrb_nxt = mem_wstrb;
        ag_load       = 1'b0;
        ag_advance    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (fb_aw_valid && fb_aw_ready) begin
                    ag_load       = 1'b1;
                    beat_cnt_nxt  = fb_aw_len;
                    bad_burst_nxt = (fb_aw_size != SIZE_WORD) || (fb_aw_burst == BURST_WRAP);
                    err_nxt       = bad_burst_nxt;
                    state_nxt     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fb_w_valid && fb_w_ready) begin
                    ag_advance = 1'b1;
                    // The counter ends the burst; w_last is only cross-checked.
                    if (fb_w_last != last_beat_c) begin
                        err_nxt = 1'b1;
                    end
                    if (!bad_burst) begin
                        if (!in_range_c) begin
                            err_nxt = 1'b1;
                        end else if (fb_w_strb != '0) begin
                            mem_we_nxt    = 1'b1;
                            mem_addr_nxt  = word_idx_c;
                            mem_wdata_nxt = fb_w_data;
                            mem_wstrb_nxt = fb_w_strb;
                        end
                    end
                    if (last_beat_c) begin
                        state_nxt = ST_RESP;
                    end else begin
                        beat_cnt_nxt = beat_cnt - LEN_W'(1);
                    end
                end
            end
            ST_RESP: begin
                if (fb_b_valid && fb_b_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        aw_ready_nxt = (state_nxt == ST_IDLE);
        w_ready_nxt  = (state_nxt == ST_DATA);
        b_valid_nxt  = (state_nxt == ST_RESP);
        busy_nxt     = (state_nxt != ST_IDLE);
        b_resp_nxt   = ((state_nxt == ST_RESP) && err_nxt) ? RESP_SLVERR : RESP_OKAY;
    end

endmodule

// File: tb/tb_fb_axi_wr_slave.sv
// Directed bench for fb_axi_wr_slave: expected SRAM writes are queued as
// beats are driven and popped when mem_we is seen; B responses and
// handshake timing are checked inline.
module tb_fb_axi_wr_slave;

    localparam logic [31:0] FB_BASE  = 32'h0000_0000;
    localparam int unsigned FB_WORDS = 76800;
`ifdef FB_WR_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    typedef struct {
        logic [16:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } exp_wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fb_aw_valid;
    logic [31:0] fb_aw_addr;
    logic [7:0]  fb_aw_len;
    logic [2:0]  fb_aw_size;
    logic [1:0]  fb_aw_burst;
    logic        fb_aw_ready;
    logic [31:0] fb_w_data;
    logic [3:0]  fb_w_strb;
    logic        fb_w_last;
    logic        fb_w_valid;
    logic        fb_w_ready;
    logic        fb_b_valid;
    logic [1:0]  fb_b_resp;
    logic        fb_b_ready;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    exp_wr_t     wq[$];
    logic [31:0] bd[16];
    logic [3:0]  bs[16];
    logic        bl[16];

    fb_axi_wr_slave dut (
        .clk         (clk),
        .rst         (rst),
        .fb_aw_valid (fb_aw_valid),
        .fb_aw_addr  (fb_aw_addr),
        .fb_aw_len   (fb_aw_len),
        .fb_aw_size  (fb_aw_size),
        .fb_aw_burst (fb_aw_burst),
        .fb_aw_ready (fb_aw_ready),
        .fb_w_data   (fb_w_data),
        .fb_w_strb   (fb_w_strb),
        .fb_w_last   (fb_w_last),
        .fb_w_valid  (fb_w_valid),
        .fb_w_ready  (fb_w_ready),
        .fb_b_valid  (fb_b_valid),
        .fb_b_resp   (fb_b_resp),
        .fb_b_ready  (fb_b_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard side: every SRAM write must match the oldest expected one.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 64'(mem_we), 64'd0);
            end else begin
                exp_wr_t e;
                e = wq.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
                check("wr_strb", 64'(mem_wstrb), 64'(e.strb));
            end
        end
    end

    task automatic fill(input int len, input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            bd[i] = base + 32'(i);
            bs[i] = 4'hF;
            bl[i] = (i == len);
        end
    endtask

    // Present AW at a negedge; returns at the negedge after the handshake.
    task automatic do_aw(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst);
        int n;
        @(negedge clk);
        fb_aw_valid = 1'b1;
        fb_aw_addr  = addr;
        fb_aw_len   = 8'(len);
        fb_aw_size  = size;
        fb_aw_burst = burst;
        n = 0;
        while (fb_aw_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("aw_ready_wait", 64'(n < 50), 64'd1);
        @(negedge clk);
        fb_aw_valid = 1'b0;
        check("w_ready_after_aw", 64'(fb_w_ready), 64'd1);
        check("busy_in_burst", 64'(busy), 64'd1);
    endtask

    task automatic do_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst);
        logic        bad, err, inr;
        logic [31:0] a, w;
        logic [16:0] word;
        bad = (size != 3'b010) || (burst == 2'd2);
        err = bad;
        a   = addr;
        do_aw(addr, len, size, burst);
        for (int i = 0; i <= len; i++) begin
            if (bl[i] != (i == len)) err = 1'b1;
            if (RANGE_CHK) begin
                w    = (a - FB_BASE) >> 2;
                inr  = (w < FB_WORDS);
                word = w[16:0];
            end else begin
                inr  = 1'b1;
                word = a[18:2];
            end
            if (!bad) begin
                if (!inr) err = 1'b1;
                else if (bs[i] != 4'h0) wq.push_back('{word, bd[i], bs[i]});
            end
            check("w_ready_beat", 64'(fb_w_ready), 64'd1);
            fb_w_valid = 1'b1;
            fb_w_data  = bd[i];
            fb_w_strb  = bs[i];
            fb_w_last  = bl[i];
            @(negedge clk);
            if (burst == 2'd1) a = a + 32'd4;
        end
        fb_w_valid = 1'b0;
        fb_w_last  = 1'b0;
        check("b_valid_after_last", 64'(fb_b_valid), 64'd1);
        check("b_resp", 64'(fb_b_resp), err ? 64'd2 : 64'd0);
        @(negedge clk);
        check("b_valid_hold", 64'(fb_b_valid), 64'd1);
        check("aw_ready_during_b", 64'(fb_aw_ready), 64'd0);
        fb_b_ready = 1'b1;
        @(negedge clk);
        fb_b_ready = 1'b0;
        check("b_valid_dropped", 64'(fb_b_valid), 64'd0);
        check("aw_ready_after_b", 64'(fb_aw_ready), 64'd1);
        check("busy_after_b", 64'(busy), 64'd0);
        check("writes_drained", 64'(wq.size()), 64'd0);
    endtask

    task automatic check_reset_values();
        check("rst_aw_ready", 64'(fb_aw_ready), 64'd1);
        check("rst_w_ready", 64'(fb_w_ready), 64'd0);
        check("rst_b_valid", 64'(fb_b_valid), 64'd0);
        check("rst_b_resp", 64'(fb_b_resp), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        rst         = 1'b1;
        fb_aw_valid = 1'b0;
        fb_aw_addr  = '0;
        fb_aw_len   = '0;
        fb_aw_size  = 3'b010;
        fb_aw_burst = 2'd1;
        fb_w_data   = '0;
        fb_w_strb   = '0;
        fb_w_last   = 1'b0;
        fb_w_valid  = 1'b0;
        fb_b_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);

        // W presented while idle must not be accepted.
        fb_w_valid = 1'b1;
        fb_w_data  = 32'hDEAD_BEEF;
        fb_w_strb  = 4'hF;
        repeat (3) begin
            @(negedge clk);
            check("w_ready_idle", 64'(fb_w_ready), 64'd0);
        end
        fb_w_valid = 1'b0;

        // INCR from 0x10: words 4..7, data 1..4.
        fill(3, 32'd1);
        do_burst(32'h0000_0010, 3, 3'b010, 2'd1);

        // FIXED at 0x40 with walking strobes.
        fill(2, 32'hA0);
        bs[0] = 4'h1; bs[1] = 4'h2; bs[2] = 4'h4;
        do_burst(32'h0000_0040, 2, 3'b010, 2'd0);

        // Illegal size, then WRAP: beats consumed, nothing written.
        fill(1, 32'hB0);
        do_burst(32'h0000_0100, 1, 3'b001, 2'd1);
        fill(1, 32'hC0);
        do_burst(32'h0000_0100, 1, 3'b010, 2'd2);

        // Early w_last on beat 1 of a 4-beat burst.
        fill(3, 32'hD0);
        bl[1] = 1'b1; bl[3] = 1'b0;
        do_burst(32'h0000_0200, 3, 3'b010, 2'd1);

        // Unaligned start (low bits ignored) and a zero-strobe beat.
        fill(1, 32'hE0);
        bs[0] = 4'h0;
        do_burst(32'h0000_0022, 1, 3'b010, 2'd1);

        // Burst crossing the end of the framebuffer window.
        fill(3, 32'hF0);
        do_burst(32'((FB_WORDS - 2) * 4), 3, 3'b010, 2'd1);

        // Reset after two beats: second write squashed, no B.
        fill(3, 32'h55);
        do_aw(32'h0000_0200, 3, 3'b010, 2'd1);
        fb_w_valid = 1'b1;
        fb_w_data  = bd[0];
        fb_w_strb  = 4'hF;
        fb_w_last  = 1'b0;
        wq.push_back('{17'd128, bd[0], 4'hF});
        @(negedge clk);
        fb_w_data = bd[1];
        @(posedge clk);
        #1;
        rst        = 1'b1;
        fb_w_valid = 1'b0;
        @(negedge clk);
        check_reset_values();
        check("rst_writes_drained", 64'(wq.size()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_b_after_rst", 64'(fb_b_valid), 64'd0);
        end

        // Fresh burst after the reset completes normally.
        fill(3, 32'h60);
        do_burst(32'h0000_0300, 3, 3'b010, 2'd1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_axi_wr_slave.md
# fb_axi_wr_slave

AXI4 write-channel responder that terminates the framebuffer write path driven by the graphics LSU (`fb_aw_*`/`fb_w_*`/`fb_b_*`) and commits the beats into the framebuffer SRAM write port. It accepts one burst at a time, generates per-beat word addresses, applies byte strobes and returns one write response per burst. It sits between the compute-unit framebuffer AXI master and the display/framebuffer memory.

## Interface
- `FB_BASE`, 32'h0000_0000: byte base address of the framebuffer window.
- `FB_WORDS`, 76800: window size in 32-bit words.
- `MEM_AW`, 17: SRAM word-address width.
---
- `clk`  in  1  clock
- `rst`  in  1  **asynchronous, active-high** reset
- `fb_aw_valid`  in  1  write-address valid
- `fb_aw_addr`  in  32  burst start byte address
- `fb_aw_len`  in  8  beats minus 1
- `fb_aw_size`  in  3  beat size; only 3'b010 is legal
- `fb_aw_burst`  in  2  0=FIXED, 1=INCR, 2=WRAP
- `fb_aw_ready`  out  1  address accepted
- `fb_w_data`  in  32  write data
- `fb_w_strb`  in  4  byte strobes
- `fb_w_last`  in  1  last beat marker from the master
- `fb_w_valid`  in  1  data valid
- `fb_w_ready`  out  1  data accepted
- `fb_b_valid`  out  1  response valid
- `fb_b_resp`  out  2  00=OKAY, 10=SLVERR
- `fb_b_ready`  in  1  response accepted
- `mem_we`  out  1  SRAM write enable, one-cycle pulse
- `mem_addr`  out  MEM_AW  SRAM word address
- `mem_wdata`  out  32  SRAM write data
- `mem_wstrb`  out  4  SRAM byte enables
- `busy`  out  1  a burst is in flight (state != IDLE)

## Operation
- FSM has three states: IDLE, DATA, RESP. Only one burst is outstanding at a time.
- **IDLE:** `fb_aw_ready`=1. On an AW handshake, latch addr, `len` into the beat counter and burst type, clear `err`, then go to DATA.
- **AW checks:** if size != 2 or burst == WRAP, set `err`. All beats of that burst are still consumed, but none are written.
- **DATA:** `fb_w_ready`=1. On each W handshake:
  - If the beat is legal and in range, register the SRAM write: `mem_addr` = word index, data and strobes passed through.
  - If `fb_w_strb`=0, `mem_we` is not asserted and the beat counts as OK.
  - Address advance: INCR adds 4, modulo 2^32. FIXED holds the address. `addr[1:0]` is ignored.
- **Burst end:** the beat counter is authoritative. After beat `len`+1, go to RESP. If `fb_w_last` disagrees with the counter on any beat, set `err`; early `w_last` does not end the burst.
- **RESP:** `fb_b_valid`=1 and `fb_b_resp` = `err` ? SLVERR : OKAY. Both hold until `fb_b_ready`, then return to IDLE.
- A W beat presented while in IDLE or RESP is not accepted.

## Timing
- **Reset values:** state IDLE, `fb_aw_ready`=1, `fb_w_ready`=0, `fb_b_valid`=0, `fb_b_resp`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `busy`=0.
- **Reset mid-burst:** the burst is abandoned, no B is issued, and a pending `mem_we` is cleared.
- **Handshake to write:** `mem_*` is registered and valid the cycle after a W handshake. `mem_we` is a single-cycle pulse.
- **Cycle sequence:** AW handshake in cycle N, `fb_w_ready`=1 from N+1. The last W handshake in cycle M gives `fb_b_valid`=1 in M+1.
- **Throughput:** one beat per cycle. The minimum burst cost is `len`+1 beats, plus 1 AW cycle and at least 1 B cycle.
- **Back-to-back bursts:** `fb_aw_ready` returns the cycle after the B handshake. There is no AW/B overlap.

## Configuration
- `FB_WR_RANGE_CHECK_EN` defined: each beat computes `(addr - FB_BASE) >> 2`, unsigned.
  - If the result is >= `FB_WORDS`, the write is suppressed and `err` is set.
  - `mem_addr` is the in-window index.
- `FB_WR_RANGE_CHECK_EN` undefined: `mem_addr = addr[MEM_AW+1:2]` with no window check.
  - SLVERR comes only from size, burst type or `w_last` errors.

## Structure
- **Package `fb_axi_pkg`:** burst codes (FIXED/INCR/WRAP), resp codes (OKAY/SLVERR), legal size constant 3'b010, and the FSM state enum.
- **Sub-module `fb_wr_addr_gen`:** holds the current address, produces the next address (INCR/FIXED), the word index and the in-range flag.
- The top level holds the FSM, the beat counter, the error flag and the `mem_*` registers.

## Test plan
- INCR, addr 0x0000_0010, len 3, strb 4'hF, data 1..4 -> `mem_we` at words 4,5,6,7 with data 1..4, then B=OKAY.
- FIXED, addr 0x40, len 2, strbs 4'h1, 4'h2, 4'h4 -> three writes to word 16 with those strobes, then OKAY.
- size 3'b001, len 1 -> both beats accepted, no `mem_we`, B=SLVERR. Same with burst=WRAP.
- `w_last` asserted on beat 1 of a len=3 burst -> all 4 beats consumed, B=SLVERR.
- With `FB_WR_RANGE_CHECK_EN`: INCR starting at word `FB_WORDS`-2, len 3 -> 2 writes, 2 suppressed, SLVERR. Without it: 4 writes, OKAY.
- `rst` pulsed after 2 of 4 beats -> outputs take reset values, no B; a new burst then completes with OKAY.
